button_pulse_debounce: RTL

//  Upstream stage of the up-counter on the iCE40 board: turns a raw, bouncing, asynchronous

---
 rtl/btn_pkg.sv | 22 ++
 rtl/sync_ff.sv | 25 ++
 rtl/button_pulse_debounce.sv | 113 +++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button front end: FSM state encoding
// and the constant function that sizes the qualification/hold/repeat timer.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_QUAL,
        HELD,
        REPEAT,
        RELEASE_QUAL
    } btn_state_e;

    // One timer serves every state, so it must hold the largest terminal count.
    function automatic int timer_width(input int debounce, input int hold, input int rpt);
        int longest;
        longest = debounce;
        if (hold > longest) longest = hold;
        if (rpt > longest) longest = rpt;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// N-flop synchroniser for an asynchronous single-bit input; resets to 0.
// Generic so other board pins can reuse it.
module sync_ff #(
    parameter int STAGES_P = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES_P-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES_P-2:0], d};
        end
    end

    assign q = chain[STAGES_P-1];

endmodule

// File: rtl/button_pulse_debounce.sv
// Raw push-button to clean single-cycle increment pulses: synchronise, debounce
// press and release, auto-repeat while held, and export the debounced level.
module button_pulse_debounce
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES_P     = 2,
    parameter int DEBOUNCE_CYCLES_P = 16,
    parameter int HOLD_CYCLES_P     = 1024,
    parameter int REPEAT_CYCLES_P   = 256,
    parameter bit REPEAT_EN_P       = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic pulse_o,
    output logic level_o
);

    localparam int CNT_W = timer_width(DEBOUNCE_CYCLES_P, HOLD_CYCLES_P, REPEAT_CYCLES_P);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES_P - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES_P - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES_P - 1);

    btn_state_e       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             pulse_n;
    logic             level_n;
    logic             s;

    sync_ff #(.STAGES_P(SYNC_STAGES_P)) u_sync (
        .clk (clk_i),
        .rst (reset_i),
        .d   (btn_i),
        .q   (s)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (s) state_n = PRESS_QUAL;
            end
            PRESS_QUAL: begin
                if (!s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                end
            end
            HELD: begin
                if (!s) begin
                    state_n = RELEASE_QUAL;
                    cnt_n   = '0;
                end else if (cnt == HOLD_LAST) begin
                    if (REPEAT_EN_P) begin
                        state_n = REPEAT;
                        cnt_n   = '0;
                        pulse_n = 1'b1;
                    end else begin
                        cnt_n = cnt;
                    end
                end
            end
            REPEAT: begin
                // A release arriving on the same edge as a due repeat suppresses the pulse.
                if (!s) begin
                    state_n = RELEASE_QUAL;
                    cnt_n   = '0;
                end else if (cnt == REP_LAST) begin
                    cnt_n   = '0;
                    pulse_n = 1'b1;
                end
            end
            RELEASE_QUAL: begin
                // Bounce back high restarts the hold window without counting a new press.
                if (s) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        level_n = (state_n == HELD) || (state_n == REPEAT) || (state_n == RELEASE_QUAL);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            cnt     <= '0;
            pulse_o <= 1'b0;
            level_o <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pulse_o <= pulse_n;
            level_o <= level_n;
        end
    end

endmodule
